// File: rtl/coin_payer.sv
// Customer-side coin controller: pays a drink price from a 1/5/10-lei wallet as B pulses,
// then credits R1/R5 change and checks it against the amount paid when the bottle arrives.
module coin_payer #(
    parameter int unsigned PRICE   = 3,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_n1,
    input  logic [CNT_W-1:0] load_n5,
    input  logic [CNT_W-1:0] load_n10,
    input  logic             buy,
    input  logic [1:0]       mode,
    input  logic             R1,
    input  logic             R5,
    input  logic             STICLA,
    output logic             B1,
    output logic             B5,
    output logic             B10,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] n1,
    output logic [CNT_W-1:0] n5,
    output logic [CNT_W-1:0] n10,
    output logic [4:0]       change_sum
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StInsert, StWait} state_e;
    typedef enum logic [1:0] {Coin1, Coin5, Coin10} coin_e;

    state_e           state_q, state_d;
    coin_e            coin_q, coin_d, buy_coin;
    logic [4:0]       paid_q, paid_d;
    logic [2:0]       step_q, step_d, last_step;
    logic [TW-1:0]    timer_q, timer_d;
    logic             b1_q, b1_d, b5_q, b5_d, b10_q, b10_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0] n1_q, n1_d, n5_q, n5_d, n10_q, n10_d;
    logic [4:0]       cs_q, cs_d, cs_sum;
    logic             funds_ok;

    // Coin choice is resolved from the wallet as it stands at the buy edge.
    always_comb begin
        buy_coin = Coin10;
        unique case (mode)
            2'b00:   buy_coin = Coin1;
            2'b01:   buy_coin = Coin5;
            2'b10:   buy_coin = Coin10;
            default: buy_coin = (n1_q >= CNT_W'(3)) ? Coin1 :
                                (n5_q != '0)        ? Coin5 : Coin10;
        endcase
        funds_ok = (buy_coin == Coin1) ? (n1_q >= CNT_W'(3)) :
                   (buy_coin == Coin5) ? (n5_q != '0) : (n10_q != '0);
        // 1-leu payment spans five INSERT cycles: pulse, gap, pulse, gap, pulse.
        last_step = (coin_q == Coin1) ? 3'd4 : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!load && buy && funds_ok) state_d = StInsert;
            StInsert: if (step_q == last_step) state_d = StWait;
            StWait:   if (STICLA || timer_q == TW'(TIMEOUT - 1)) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        n1_d    = n1_q;
        n5_d    = n5_q;
        n10_d   = n10_q;
        cs_d    = cs_q;
        cs_sum  = cs_q;
        paid_d  = paid_q;
        coin_d  = coin_q;
        step_d  = step_q;
        timer_d = timer_q;
        busy_d  = busy_q;
        b1_d    = 1'b0;
        b5_d    = 1'b0;
        b10_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    n1_d  = load_n1;
                    n5_d  = load_n5;
                    n10_d = load_n10;
                end else if (buy) begin
                    if (!funds_ok) begin
                        err_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        cs_d   = '0;
                        coin_d = buy_coin;
                        step_d = '0;
                        unique case (buy_coin)
                            Coin1: begin
                                paid_d = 5'd3;
                                b1_d   = 1'b1;
                                n1_d   = n1_q - 1'b1;
                            end
                            Coin5: begin
                                paid_d = 5'd5;
                                b5_d   = 1'b1;
                                n5_d   = n5_q - 1'b1;
                            end
                            default: begin
                                paid_d = 5'd10;
                                b10_d  = 1'b1;
                                n10_d  = n10_q - 1'b1;
                            end
                        endcase
                    end
                end
            end
            StInsert: begin
                if (step_q != last_step) begin
                    step_d = step_q + 3'd1;
                    if (step_q[0]) begin
                        b1_d = 1'b1;
                        n1_d = n1_q - 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            StWait: begin
                if (R1 && n1_q != '1) n1_d = n1_q + 1'b1;
                if (R5 && n5_q != '1) n5_d = n5_q + 1'b1;
                cs_sum = cs_q + {4'b0, R1} + (R5 ? 5'd5 : 5'd0);
                cs_d   = cs_sum;
                if (STICLA) begin
                    busy_d = 1'b0;
                    if (cs_sum == paid_q - 5'(PRICE)) done_d = 1'b1;
                    else                              err_d  = 1'b1;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coin_q  <= Coin1;
            paid_q  <= '0;
            step_q  <= '0;
            timer_q <= '0;
            b1_q    <= 1'b0;
            b5_q    <= 1'b0;
            b10_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            n1_q    <= '0;
            n5_q    <= '0;
            n10_q   <= '0;
            cs_q    <= '0;
        end else begin
            coin_q  <= coin_d;
            paid_q  <= paid_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            b1_q    <= b1_d;
            b5_q    <= b5_d;
            b10_q   <= b10_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            n1_q    <= n1_d;
            n5_q    <= n5_d;
            n10_q   <= n10_d;
            cs_q    <= cs_d;
        end
    end

    assign B1         = b1_q;
    assign B5         = b5_q;
    assign B10        = b10_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign n1         = n1_q;
    assign n5         = n5_q;
    assign n10        = n10_q;
    assign change_sum = cs_q;

endmodule

// File: tb/tb_coin_payer.sv
// Bench for coin_payer: directed purchases plus randomized ones, checked every cycle against
// a transaction-level wallet/change model.
module tb_coin_payer;

    localparam int PRICE   = 3;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [CNT_W-1:0] load_n1 = '0;
    logic [CNT_W-1:0] load_n5 = '0;
    logic [CNT_W-1:0] load_n10 = '0;
    logic             buy = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             R1 = 1'b0;
    logic             R5 = 1'b0;
    logic             STICLA = 1'b0;
    logic             B1, B5, B10, busy, done, err;
    logic [CNT_W-1:0] n1, n5, n10;
    logic [4:0]       change_sum;

    int vec_cnt = 0;
    int miscmp  = 0;
    int m_n1 = 0, m_n5 = 0, m_n10 = 0, m_cs = 0;
    logic [2:0] resp_q[$];  // per WAIT cycle: {STICLA, R5, R1}

    always #5 clk = ~clk;

    coin_payer #(.PRICE(PRICE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_n1(load_n1), .load_n5(load_n5),
        .load_n10(load_n10), .buy(buy), .mode(mode), .R1(R1), .R5(R5), .STICLA(STICLA),
        .B1(B1), .B5(B5), .B10(B10), .busy(busy), .done(done), .err(err),
        .n1(n1), .n5(n5), .n10(n10), .change_sum(change_sum)
    );

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int b1, input int b5, input int b10,
                             input int bz, input int dn, input int er);
        check({tag, ".B1"}, int'(B1), b1);
        check({tag, ".B5"}, int'(B5), b5);
        check({tag, ".B10"}, int'(B10), b10);
        check({tag, ".busy"}, int'(busy), bz);
        check({tag, ".done"}, int'(done), dn);
        check({tag, ".err"}, int'(err), er);
        check({tag, ".n1"}, int'(n1), m_n1);
        check({tag, ".n5"}, int'(n5), m_n5);
        check({tag, ".n10"}, int'(n10), m_n10);
        check({tag, ".change"}, int'(change_sum), m_cs);
    endtask

    function automatic int coin_of(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b01:   return 5;
            2'b10:   return 10;
            default: return (m_n1 >= 3) ? 1 : (m_n5 > 0) ? 5 : 10;
        endcase
    endfunction

    function automatic bit can_pay(input int c);
        if (c == 1) return m_n1 >= 3;
        if (c == 5) return m_n5 > 0;
        return m_n10 > 0;
    endfunction

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        m_n1 = 0; m_n5 = 0; m_n10 = 0; m_cs = 0;
        check_all(tag, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic load_wallet(input int a, input int b, input int c);
        load = 1'b1;
        load_n1 = CNT_W'(a); load_n5 = CNT_W'(b); load_n10 = CNT_W'(c);
        tick();
        load = 1'b0;
        m_n1 = a; m_n5 = b; m_n10 = c;
        check_all("load", 0, 0, 0, 0, 0, 0);
    endtask

    // One purchase: buy, check payment pulses with noise on ignored inputs, then play resp_q.
    task automatic run_buy(input logic [1:0] m, input string tag);
        int c = coin_of(m);
        int paid = (c == 1) ? 3 : c;
        mode = m; buy = 1'b1; load = 1'b0;
        tick();
        buy = 1'b0;
        if (!can_pay(c)) begin
            check_all({tag, ".nofunds"}, 0, 0, 0, 0, 0, 1);
            tick();
            check_all({tag, ".nofunds2"}, 0, 0, 0, 0, 0, 0);
            resp_q.delete();
            return;
        end
        m_cs = 0;
        for (int k = 0; k < ((c == 1) ? 5 : 1); k++) begin
            bit p = (k % 2 == 0);
            if (p) begin
                if (c == 1) m_n1--;
                else if (c == 5) m_n5--;
                else m_n10--;
            end
            check_all({tag, ".ins"}, int'(p && c == 1), int'(p && c == 5), int'(p && c == 10),
                      1, 0, 0);
            R1 = 1'($urandom); R5 = 1'($urandom); STICLA = 1'($urandom);
            load = 1'($urandom); buy = 1'($urandom);
            load_n1 = CNT_W'($urandom); load_n5 = CNT_W'($urandom);
            load_n10 = CNT_W'($urandom);
            tick();
        end
        R1 = 1'b0; R5 = 1'b0; STICLA = 1'b0; load = 1'b0; buy = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            logic [2:0] r = (i < resp_q.size()) ? resp_q[i] : 3'b000;
            {STICLA, R5, R1} = r;
            tick();
            {STICLA, R5, R1} = 3'b000;
            if (r[0] && m_n1 < MAXC) m_n1++;
            if (r[1] && m_n5 < MAXC) m_n5++;
            m_cs = (m_cs + int'(r[0]) + 5 * int'(r[1])) % 32;
            if (r[2]) begin
                bit ok = (m_cs == paid - PRICE);
                check_all({tag, ".end"}, 0, 0, 0, 0, int'(ok), int'(!ok));
                break;
            end else if (i == TIMEOUT - 1) begin
                check_all({tag, ".tmo"}, 0, 0, 0, 0, 0, 1);
            end else begin
                check_all({tag, ".wait"}, 0, 0, 0, 1, 0, 0);
            end
        end
        tick();
        check_all({tag, ".idle"}, 0, 0, 0, 0, 0, 0);
        resp_q.delete();
    endtask

    initial begin
        // 1: three 1-leu pulses, exact (zero) change
        do_reset("t1.reset");
        load_wallet(3, 1, 1);
        resp_q = '{3'b100};
        run_buy(2'b00, "t1");
        // 2: one 5-lei coin, two 1-leu change
        resp_q = '{3'b001, 3'b001, 3'b100};
        run_buy(2'b01, "t2");
        // 3: one 10-lei coin, 5+1+1 change
        resp_q = '{3'b010, 3'b001, 3'b001, 3'b100};
        run_buy(2'b10, "t3");
        // 4: not enough 1-leu coins
        load_wallet(2, 0, 0);
        run_buy(2'b00, "t4");
        // 5: timeout, then wrong change
        load_wallet(0, 2, 0);
        run_buy(2'b01, "t5a");
        resp_q = '{3'b001, 3'b100};
        run_buy(2'b01, "t5b");
        // load wins over a same-cycle buy
        load = 1'b1; buy = 1'b1; mode = 2'b00;
        load_n1 = 4'd5; load_n5 = 4'd5; load_n10 = 4'd5;
        tick();
        load = 1'b0; buy = 1'b0;
        m_n1 = 5; m_n5 = 5; m_n10 = 5;
        check_all("ldbuy", 0, 0, 0, 0, 0, 0);
        tick();
        check_all("ldbuy2", 0, 0, 0, 0, 0, 0);
        // 6: reset during INSERT, then saturation of n1
        mode = 2'b01; buy = 1'b1;
        tick();
        buy = 1'b0;
        check("t6.B5", int'(B5), 1);
        do_reset("t6.reset");
        load_wallet(15, 0, 1);
        resp_q = '{3'b001, 3'b100};
        run_buy(2'b10, "t6sat");

        for (int it = 0; it < 40; it++) begin
            logic [1:0] m;
            int c, need, p, kind, r5pos;
            if ($urandom_range(0, 2) == 0)
                load_wallet($urandom_range(0, MAXC), $urandom_range(0, 3), $urandom_range(0, 3));
            m = 2'($urandom_range(0, 3));
            c = coin_of(m);
            need = ((c == 1) ? 3 : c) - PRICE;
            kind = $urandom_range(0, 2);
            p = $urandom_range(2, TIMEOUT - 1);
            r5pos = $urandom_range(0, p);
            if (kind == 2) begin
                for (int j = 0; j < TIMEOUT; j++) resp_q.push_back({1'b0, 2'($urandom)});
            end else begin
                for (int j = 0; j <= p; j++) begin
                    logic [2:0] v = 3'b000;
                    if (kind == 1) v[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                    else begin
                        if (need > 0 && (j == p || j == p - 1)) v[0] = 1'b1;
                        if (need == 7 && j == r5pos) v[1] = 1'b1;
                    end
                    if (j == p) v[2] = 1'b1;
                    resp_q.push_back(v);
                end
            end
            run_buy(m, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
